// File: rtl/vreg_pkg.sv
// Shared geometry and lane helpers for the multi-write vector register file.
package vreg_pkg;

    localparam int LANE_W     = 32;
    localparam int LANES      = 4;
    localparam int DATA_WIDTH = LANE_W * LANES;
    localparam int ADDR_WIDTH = 4;
    localparam int NREG       = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] vec_t;
    typedef logic [LANE_W-1:0]     lane_t;

    // Lane i occupies bits [i*LANE_W +: LANE_W].
    function automatic lane_t lane_of(input vec_t v, input int i);
        return v[i*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/vreg_lane_merge.sv
// Per-lane merge of stored data with two masked writers; port B wins where both write.
module vreg_lane_merge
    import vreg_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] old_data,
    input  logic                  en_a,
    input  logic [LANES-1:0]      mask_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  en_b,
    input  logic [LANES-1:0]      mask_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] merged
);

    always_comb begin
        merged = old_data;
        for (int i = 0; i < LANES; i++) begin
            if (en_b && mask_b[i]) begin
                merged[i*LANE_W +: LANE_W] = lane_of(data_b, i);
            end else if (en_a && mask_a[i]) begin
                merged[i*LANE_W +: LANE_W] = lane_of(data_a, i);
            end
        end
    end

endmodule

// File: rtl/vreg_file_mw.sv
// Two-write, two-read vector register file with lane masks, optional same-cycle
// write-to-read bypass and a per-register busy scoreboard.
module vreg_file_mw
    import vreg_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] w_addr_a,
    input  logic [LANES-1:0]      w_mask_a,
    input  logic [DATA_WIDTH-1:0] data_in_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] w_addr_b,
    input  logic [LANES-1:0]      w_mask_b,
    input  logic [DATA_WIDTH-1:0] data_in_b,
    input  logic                  re_a,
    input  logic [ADDR_WIDTH-1:0] r_addr_a,
    input  logic                  re_b,
    input  logic [ADDR_WIDTH-1:0] r_addr_b,
    output logic [DATA_WIDTH-1:0] data_out_a,
    output logic [DATA_WIDTH-1:0] data_out_b,
    input  logic                  rsv_en,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    output logic [NREG-1:0]       busy
);

    logic [DATA_WIDTH-1:0] ram     [NREG];
    logic [DATA_WIDTH-1:0] wr_next [NREG];
    logic [DATA_WIDTH-1:0] byp_a, byp_b, rd_a, rd_b;
    logic [NREG-1:0]       busy_next;

    // Every register gets its own merge so both ports can hit different targets.
    for (genvar g = 0; g < NREG; g++) begin : g_wr
        vreg_lane_merge u_wr_merge (
            .old_data (ram[g]),
            .en_a     (we_a && (w_addr_a == ADDR_WIDTH'(g))),
            .mask_a   (w_mask_a),
            .data_a   (data_in_a),
            .en_b     (we_b && (w_addr_b == ADDR_WIDTH'(g))),
            .mask_b   (w_mask_b),
            .data_b   (data_in_b),
            .merged   (wr_next[g])
        );
    end

    vreg_lane_merge u_byp_a (
        .old_data (ram[r_addr_a]),
        .en_a     (we_a && (w_addr_a == r_addr_a)),
        .mask_a   (w_mask_a),
        .data_a   (data_in_a),
        .en_b     (we_b && (w_addr_b == r_addr_a)),
        .mask_b   (w_mask_b),
        .data_b   (data_in_b),
        .merged   (byp_a)
    );

    vreg_lane_merge u_byp_b (
        .old_data (ram[r_addr_b]),
        .en_a     (we_a && (w_addr_a == r_addr_b)),
        .mask_a   (w_mask_a),
        .data_a   (data_in_a),
        .en_b     (we_b && (w_addr_b == r_addr_b)),
        .mask_b   (w_mask_b),
        .data_b   (data_in_b),
        .merged   (byp_b)
    );

    assign rd_a = BYPASS ? byp_a : ram[r_addr_a];
    assign rd_b = BYPASS ? byp_b : ram[r_addr_b];

    // Writes retire a producer; a reservation in the same cycle is a new producer and wins.
    always_comb begin
        busy_next = busy;
        if (we_a) busy_next[w_addr_a] = 1'b0;
        if (we_b) busy_next[w_addr_b] = 1'b0;
        if (rsv_en) busy_next[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) ram[i] <= '0;
            busy       <= '0;
            data_out_a <= '0;
            data_out_b <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) ram[i] <= wr_next[i];
            busy <= busy_next;
            if (re_a) data_out_a <= rd_a;
            if (re_b) data_out_b <= rd_b;
        end
    end

endmodule

// File: tb/tb_vreg_file_mw.sv
// Directed bench for vreg_file_mw; a BYPASS=0 twin shares every input.
module tb_vreg_file_mw;
    import vreg_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  we_a, we_b, re_a, re_b, rsv_en;
    logic [ADDR_WIDTH-1:0] w_addr_a, w_addr_b, r_addr_a, r_addr_b, rsv_addr;
    logic [LANES-1:0]      w_mask_a, w_mask_b;
    logic [DATA_WIDTH-1:0] data_in_a, data_in_b;
    logic [DATA_WIDTH-1:0] data_out_a, data_out_b, nb_data_out_a, nb_data_out_b;
    logic [NREG-1:0]       busy, nb_busy;

    int check_cnt = 0;
    int pass_cnt  = 0;
    logic [DATA_WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    vreg_file_mw #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst),
        .we_a(we_a), .w_addr_a(w_addr_a), .w_mask_a(w_mask_a), .data_in_a(data_in_a),
        .we_b(we_b), .w_addr_b(w_addr_b), .w_mask_b(w_mask_b), .data_in_b(data_in_b),
        .re_a(re_a), .r_addr_a(r_addr_a), .re_b(re_b), .r_addr_b(r_addr_b),
        .data_out_a(data_out_a), .data_out_b(data_out_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy)
    );

    vreg_file_mw #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst),
        .we_a(we_a), .w_addr_a(w_addr_a), .w_mask_a(w_mask_a), .data_in_a(data_in_a),
        .we_b(we_b), .w_addr_b(w_addr_b), .w_mask_b(w_mask_b), .data_in_b(data_in_b),
        .re_a(re_a), .r_addr_a(r_addr_a), .re_b(re_b), .r_addr_b(r_addr_b),
        .data_out_a(nb_data_out_a), .data_out_b(nb_data_out_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(nb_busy)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a = 0; w_addr_a = '0; w_mask_a = '0; data_in_a = '0;
        we_b = 0; w_addr_b = '0; w_mask_b = '0; data_in_b = '0;
        re_a = 0; re_b = 0; rsv_en = 0; rsv_addr = '0;
    endtask

    task automatic write_a(input logic [ADDR_WIDTH-1:0] a, input logic [LANES-1:0] m,
                           input logic [DATA_WIDTH-1:0] d);
        we_a = 1; w_addr_a = a; w_mask_a = m; data_in_a = d;
    endtask

    task automatic write_b(input logic [ADDR_WIDTH-1:0] a, input logic [LANES-1:0] m,
                           input logic [DATA_WIDTH-1:0] d);
        we_b = 1; w_addr_b = a; w_mask_b = m; data_in_b = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [DATA_WIDTH-1:0] e, got;
        idle();
        r_addr_a = '0; r_addr_b = '0;
        rst = 1; tick(); tick(); rst = 0;
        check_cnt++; if (busy !== '0) $display("FAIL reset_busy: got %h expected 0", busy); else pass_cnt++;
        check_cnt++; if (data_out_a !== '0) $display("FAIL reset_out_a: got %h expected 0", data_out_a); else pass_cnt++;
        check_cnt++; if (data_out_b !== '0) $display("FAIL reset_out_b: got %h expected 0", data_out_b); else pass_cnt++;

        // Fill every register, reserving the even ones along the way.
        for (int r = 0; r < NREG; r += 2) begin
            write_a(ADDR_WIDTH'(r), 4'hF, {4{32'hDEADBEEF}});
            write_b(ADDR_WIDTH'(r + 1), 4'hF, {4{32'hDEADBEEF}});
            rsv_en = 1; rsv_addr = ADDR_WIDTH'(r);
            tick();
            idle();
        end
        check_cnt++; if (busy !== 16'h5555) $display("FAIL fill_busy: got %h expected 5555", busy); else pass_cnt++;
        re_a = 1; r_addr_a = 4'd0; tick(); idle();
        check_cnt++;
        if (data_out_a !== {4{32'hDEADBEEF}}) $display("FAIL fill_r0: got %h expected %h", data_out_a, {4{32'hDEADBEEF}});
        else pass_cnt++;

        rst = 1; tick(); rst = 0;
        check_cnt++; if (busy !== '0) $display("FAIL reset2_busy: got %h expected 0", busy); else pass_cnt++;
        for (int r = 0; r < NREG; r++) begin
            re_a = 1; r_addr_a = ADDR_WIDTH'(r);
            re_b = 1; r_addr_b = ADDR_WIDTH'(NREG - 1 - r);
            exp_q.push_back('0);
            exp_q.push_back('0);
            tick();
            e = exp_q.pop_front(); got = data_out_a;
            check_cnt++; if (got !== e) $display("FAIL reset_read_a r%0d: got %h expected %h", r, got, e); else pass_cnt++;
            e = exp_q.pop_front(); got = data_out_b;
            check_cnt++; if (got !== e) $display("FAIL reset_read_b r%0d: got %h expected %h", NREG - 1 - r, got, e); else pass_cnt++;
        end
        idle();
    endtask

    task automatic test_masked_write();
        logic [DATA_WIDTH-1:0] e;
        e = 128'h11111111_AAAAAAAA_33333333_AAAAAAAA;
        write_a(4'd3, 4'hF, 128'h11111111_22222222_33333333_44444444); tick(); idle();
        write_b(4'd3, 4'b0101, {4{32'hAAAAAAAA}}); tick(); idle();
        re_a = 1; r_addr_a = 4'd3;
        #2;
        check_cnt++; if (data_out_a !== '0) $display("FAIL mask_pre_edge: got %h expected 0", data_out_a); else pass_cnt++;
        tick(); idle();
        check_cnt++; if (data_out_a !== e) $display("FAIL mask_read: got %h expected %h", data_out_a, e); else pass_cnt++;
        r_addr_a = 4'd5; tick();
        check_cnt++; if (data_out_a !== e) $display("FAIL read_hold: got %h expected %h", data_out_a, e); else pass_cnt++;
        idle();
    endtask

    task automatic test_dual_write();
        logic [DATA_WIDTH-1:0] e5;
        e5 = 128'h00000001_00000001_00000002_00000002;
        write_a(4'd5, 4'hF, {4{32'h1}});
        write_b(4'd5, 4'b0011, {4{32'h2}});
        tick(); idle();
        write_a(4'd6, 4'hF, 128'h60000000_60000001_60000002_60000003);
        write_b(4'd8, 4'hF, 128'h80000000_80000001_80000002_80000003);
        tick(); idle();
        re_a = 1; r_addr_a = 4'd5; re_b = 1; r_addr_b = 4'd6; tick(); idle();
        check_cnt++; if (data_out_a !== e5) $display("FAIL conflict_r5: got %h expected %h", data_out_a, e5); else pass_cnt++;
        check_cnt++;
        if (data_out_b !== 128'h60000000_60000001_60000002_60000003)
            $display("FAIL split_r6: got %h expected %h", data_out_b, 128'h60000000_60000001_60000002_60000003);
        else pass_cnt++;
        write_a(4'd5, 4'h0, {4{32'hFFFFFFFF}}); tick(); idle();
        re_a = 1; r_addr_a = 4'd5; re_b = 1; r_addr_b = 4'd8; tick(); idle();
        check_cnt++; if (data_out_a !== e5) $display("FAIL mask0_keeps: got %h expected %h", data_out_a, e5); else pass_cnt++;
        check_cnt++;
        if (data_out_b !== 128'h80000000_80000001_80000002_80000003)
            $display("FAIL split_r8: got %h expected %h", data_out_b, 128'h80000000_80000001_80000002_80000003);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        logic [DATA_WIDTH-1:0] old_v, cafe, mix;
        old_v = {4{32'h01234567}};
        cafe  = 128'hCAFEBABE_CAFEF00D_CAFED00D_CAFE1234;
        mix   = 128'hA0A0A0A0_B0B0B0B0_B0B0B0B0_CAFE1234;
        write_a(4'd7, 4'hF, old_v); tick(); idle();
        write_a(4'd7, 4'hF, cafe);
        re_a = 1; r_addr_a = 4'd7; re_b = 1; r_addr_b = 4'd7;
        tick(); idle();
        check_cnt++; if (data_out_a !== cafe) $display("FAIL byp_a: got %h expected %h", data_out_a, cafe); else pass_cnt++;
        check_cnt++; if (data_out_b !== cafe) $display("FAIL byp_b: got %h expected %h", data_out_b, cafe); else pass_cnt++;
        check_cnt++; if (nb_data_out_a !== old_v) $display("FAIL nobyp_a: got %h expected %h", nb_data_out_a, old_v); else pass_cnt++;
        check_cnt++; if (nb_data_out_b !== old_v) $display("FAIL nobyp_b: got %h expected %h", nb_data_out_b, old_v); else pass_cnt++;

        write_a(4'd7, 4'b1100, {4{32'hA0A0A0A0}});
        write_b(4'd7, 4'b0110, {4{32'hB0B0B0B0}});
        re_a = 1; r_addr_a = 4'd7; re_b = 1; r_addr_b = 4'd7;
        tick(); idle();
        check_cnt++; if (data_out_a !== mix) $display("FAIL byp_mix_a: got %h expected %h", data_out_a, mix); else pass_cnt++;
        check_cnt++; if (data_out_b !== mix) $display("FAIL byp_mix_b: got %h expected %h", data_out_b, mix); else pass_cnt++;
        check_cnt++; if (nb_data_out_a !== cafe) $display("FAIL nobyp_mix: got %h expected %h", nb_data_out_a, cafe); else pass_cnt++;
        re_a = 1; r_addr_a = 4'd7; tick(); idle();
        check_cnt++; if (nb_data_out_a !== mix) $display("FAIL mix_stored: got %h expected %h", nb_data_out_a, mix); else pass_cnt++;
    endtask

    task automatic test_scoreboard();
        check_cnt++; if (busy !== '0) $display("FAIL sb_start: got %h expected 0", busy); else pass_cnt++;
        rsv_en = 1; rsv_addr = 4'd9; tick(); idle();
        check_cnt++; if (busy !== 16'h0200) $display("FAIL sb_reserve: got %h expected 0200", busy); else pass_cnt++;
        write_a(4'd9, 4'h0, '0); tick(); idle();
        check_cnt++; if (busy !== 16'h0000) $display("FAIL sb_mask0_clear: got %h expected 0000", busy); else pass_cnt++;
        rsv_en = 1; rsv_addr = 4'd9; write_b(4'd9, 4'hF, '0); tick(); idle();
        check_cnt++; if (busy !== 16'h0200) $display("FAIL sb_set_wins: got %h expected 0200", busy); else pass_cnt++;
        rsv_en = 1; rsv_addr = 4'd9; write_a(4'd10, 4'hF, '0); tick(); idle();
        check_cnt++; if (busy !== 16'h0200) $display("FAIL sb_rereserve: got %h expected 0200", busy); else pass_cnt++;
        write_b(4'd9, 4'h1, '0); tick(); idle();
        check_cnt++; if (busy !== 16'h0000) $display("FAIL sb_no_count: got %h expected 0000", busy); else pass_cnt++;
        check_cnt++; if (nb_busy !== 16'h0000) $display("FAIL sb_twin: got %h expected 0000", nb_busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        write_a(4'd4, 4'hF, {4{32'h55555555}}); tick(); idle();
        rst = 1;
        rsv_en = 1; rsv_addr = 4'd2;
        write_a(4'd4, 4'hF, {4{32'h77777777}});
        tick(); rst = 0; idle();
        check_cnt++; if (busy !== '0) $display("FAIL rstmid_busy: got %h expected 0", busy); else pass_cnt++;
        re_a = 1; r_addr_a = 4'd4; tick(); idle();
        check_cnt++; if (data_out_a !== '0) $display("FAIL rstmid_r4: got %h expected 0", data_out_a); else pass_cnt++;
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_masked_write();
        test_dual_write();
        test_bypass();
        test_scoreboard();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/vreg_file_mw.md
Name: vreg_file_mw

Overview:
- Second-generation vector register file for the Pixels-Machine vector datapath.
- Two write ports and two read ports, with per-lane write masks and registered reads.
- Same-cycle write-to-read bypass and a per-register busy scoreboard, so the issue stage can stall on in-flight producers.
- Sits between vector issue logic and the vector ALU/load-store writeback.

Parameters:
- LANE_W, 32, bits per lane.
- LANES, 4, lanes per vector register; DATA_WIDTH = LANE_W*LANES.
- ADDR_WIDTH, 4, register address width; NREG = 2**ADDR_WIDTH.
- BYPASS, 1, 1 = forward same-cycle write data to the read outputs; 0 = read returns pre-write contents.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- we_a  in  1  write enable, port A.
- w_addr_a  in  ADDR_WIDTH  write address, port A.
- w_mask_a  in  LANES  lane write enables, port A (bit i covers lane i).
- data_in_a  in  DATA_WIDTH  write data, port A.
- we_b, w_addr_b, w_mask_b, data_in_b: as port A, for port B.
- re_a  in  1  read enable, port A.
- r_addr_a  in  ADDR_WIDTH  read address, port A.
- re_b, r_addr_b: as port A, for port B.
- data_out_a  out  DATA_WIDTH  registered read data, port A.
- data_out_b  out  DATA_WIDTH  registered read data, port B.
- rsv_en  in  1  reserve a register (mark it busy).
- rsv_addr  in  ADDR_WIDTH  register to reserve.
- busy  out  NREG  scoreboard; bit r = register r has a pending write.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset:
  - All NREG registers cleared to 0.
  - busy = 0; data_out_a = data_out_b = 0.
  - Any write or reserve presented in the reset cycle is discarded.
- Write:
  - On a clk edge with we_x=1, lane i of ram[w_addr_x] takes data_in_x lane i wherever w_mask_x[i]=1.
  - Lanes with mask 0 keep their old value.
  - we_x=1 with mask 0 writes nothing but still clears busy (see Scoreboard).
- Write conflict (we_a & we_b, same address):
  - Lanes set in both masks take port B data.
  - Lanes set in only one mask take that port's data.
- Read:
  - 1-cycle latency: re_x sampled at edge N, data_out_x valid after edge N.
  - re_x=0 holds data_out_x at its previous value.
- Bypass, BYPASS=1:
  - A read of an address being written in the same cycle returns, per lane, the value after the write: B lane, else A lane, else stored lane.
- Bypass, BYPASS=0:
  - The same read returns the stored (old) contents.
- Scoreboard:
  - rsv_en sets busy[rsv_addr] at the edge.
  - A write (we_x=1) to register r clears busy[r].
  - Reserve and write to the same register in one cycle: set wins (new producer reservation).
  - Reserving an already-busy register leaves it busy; no counting.
  - busy is registered and has no combinational path from inputs.
- Both read ports may read the same address in one cycle; each returns identical data.

Decomposition:
- Shared package/header vreg_pkg: LANE_W, LANES, DATA_WIDTH, ADDR_WIDTH, NREG, and a lane-select function/macro (lane i = bits [i*LANE_W +: LANE_W]).
- Natural sub-module: vreg_lane_merge.
  - Combinational per-lane merge of stored data, port A and port B with the masks.
  - One instance feeds the RAM write; one feeds the bypass path of each read port.
  - This guarantees write and bypass obey identical priority.

Test Plan:
- Reset: write 0xDEADBEEF to all lanes of every register, assert rst for one cycle, read r0..r15 -> all 0; busy = 0.
- Masked write: write r3 = 0x11111111_22222222_33333333_44444444 with mask 4'b1111, then 0xAAAAAAAA repeated with mask 4'b0101, read r3 -> 0x11111111_AAAAAAAA_33333333_AAAAAAAA, one cycle after re.
- Dual-write conflict: same cycle, A writes r5 = all 0x1 with mask 1111, B writes r5 = all 0x2 with mask 0011 -> r5 = 0x00000001_00000001_00000002_00000002.
- Bypass: BYPASS=1, write r7 = 0xCAFE... while reading r7 in the same cycle -> data_out = new value. Rerun with BYPASS=0 -> old value.
- Scoreboard: rsv r9 -> busy[9]=1 next cycle. Write r9 -> busy[9]=0. Reserve and write r9 in the same cycle -> busy[9]=1.
- Reset mid-operation: rsv r2 and write r4 in the same cycle as rst=1 -> busy=0 and r4=0 afterwards.
